// File: rtl/cl_ocl_reg_arb.sv
// Round-robin sequencer sharing the single-beat AXI-Lite OCL register slave among
// NUM_REQ internal requesters; one transaction outstanding, response routed back by id.
module cl_ocl_reg_arb #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int IDW     = 3
) (
  input  logic                      clk_main_a0,
  input  logic                      rst_main_n_sync,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic [IDW-1:0]            gnt_id,
  output logic                      busy,
  output logic                      m_awvalid,
  output logic [ADDR_W-1:0]         m_awaddr,
  input  logic                      m_awready,
  output logic                      m_wvalid,
  output logic [31:0]               m_wdata,
  output logic [3:0]                m_wstrb,
  input  logic                      m_wready,
  input  logic                      m_bvalid,
  input  logic [1:0]                m_bresp,
  output logic                      m_bready,
  output logic                      m_arvalid,
  output logic [ADDR_W-1:0]         m_araddr,
  input  logic                      m_arready,
  input  logic                      m_rvalid,
  input  logic [31:0]               m_rdata,
  input  logic [1:0]                m_rresp,
  output logic                      m_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 bready_q, bready_d;
  logic                 arvalid_q, arvalid_d;
  logic                 rready_q, rready_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 busy_q, busy_d;

  logic                 found;
  logic                 grant_ok;
  logic [IDW-1:0]       gnt_sel;
  logic                 gnt_wr;
  logic [ADDR_W-1:0]    gnt_addr;
  logic [31:0]          gnt_wdata;
  logic [NUM_REQ-1:0]   id_onehot;

  // Search starts just after the last winner; the response cycle is held off so the
  // returning requester sees its response before competing again.
  always_comb begin
    found     = 1'b0;
    gnt_sel   = '0;
    gnt_wr    = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (((int'(ptr_q) + k) % NUM_REQ) == i)) begin
          found     = 1'b1;
          gnt_sel   = IDW'(i);
          gnt_wr    = req_wr[i];
          gnt_addr  = req_addr[i*ADDR_W +: ADDR_W];
          gnt_wdata = req_wdata[i*32 +: 32];
        end
      end
    end
    grant_ok = rst_main_n_sync && (state_q == IDLE) && !(|rsp_valid_q) && found;
  end

  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n_sync) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NUM_REQ - 1);
      gnt_id_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_id_q    <= gnt_id_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (grant_ok) state_d = gnt_wr ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) state_d = WR_RESP;
      WR_RESP:      if (m_bvalid) state_d = IDLE;
      RD_ADDR:      if (m_arready) state_d = RD_DATA;
      RD_DATA:      if (m_rvalid) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_ok && (gnt_sel == IDW'(i));
      id_onehot[i] = (gnt_id_q == IDW'(i));
    end

    ptr_d       = ptr_q;
    gnt_id_d    = gnt_id_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = (state_d != IDLE);

    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          ptr_d     = gnt_sel;
          gnt_id_d  = gnt_sel;
          addr_d    = gnt_addr;
          wdata_d   = gnt_wdata;
          awvalid_d = gnt_wr;
          wvalid_d  = gnt_wr;
          arvalid_d = !gnt_wr;
        end
      end
      // Address and data channels retire independently, in either order.
      WR_ADDR_DATA: begin
        awvalid_d = awvalid_q && !m_awready;
        wvalid_d  = wvalid_q && !m_wready;
        if (!awvalid_d && !wvalid_d) bready_d = 1'b1;
      end
      WR_RESP: begin
        if (m_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = id_onehot;
          rsp_rdata_d = '0;
          rsp_err_d   = |m_bresp;
        end
      end
      RD_ADDR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_DATA: begin
        if (m_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = id_onehot;
          rsp_rdata_d = m_rdata;
          rsp_err_d   = |m_rresp;
        end
      end
      default: ;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;
  assign m_awvalid = awvalid_q;
  assign m_awaddr  = addr_q;
  assign m_wvalid  = wvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = 4'hF;
  assign m_bready  = bready_q;
  assign m_arvalid = arvalid_q;
  assign m_araddr  = addr_q;
  assign m_rready  = rready_q;

endmodule
